// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample scheduler.
// Sample-rate macros fall back to a 50 MHz clock and a 1 MHz DAC rate when not supplied.
`ifndef FS
`define FS 1000000
`endif
`ifndef SYS_CLK_FREQ
`define SYS_CLK_FREQ 50000000
`endif

package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOD   = 2'd1,
        ST_TST   = 2'd2,
        ST_DRAIN = 2'd3
    } sched_st_t;

    localparam logic [7:0] MIDSCALE   = 8'h80;
    localparam int         FS_HZ      = `FS;
    localparam int         CLK_HZ     = `SYS_CLK_FREQ;
    localparam int         DIV        = CLK_HZ / FS_HZ;
    localparam int         FIFO_DEPTH = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output and asynchronous active-low clear.
// Pushes at full and pops at empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dac_sched.sv
// Arbitrates the DAC sample path between the modulator and the test source per frame,
// buffers the owner's samples and releases one per sample period.
module dac_sched #(
    parameter int         DIV        = dac_pkg::DIV,
    parameter int         FIFO_DEPTH = dac_pkg::FIFO_DEPTH,
    parameter logic [7:0] MIDSCALE   = dac_pkg::MIDSCALE
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        mod_req,
    input  logic [7:0]  mod_data,
    input  logic        mod_valid,
    output logic        mod_ready,
    input  logic        tst_req,
    input  logic [7:0]  tst_data,
    input  logic        tst_valid,
    output logic        tst_ready,
    output logic [1:0]  owner,
    output logic        sample_stb,
    output logic [7:0]  dac_sample,
    output logic [15:0] underflow_cnt
);

    import dac_pkg::*;

    localparam int              CW      = $clog2(DIV);
    localparam int              FCW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0]  cnt;
    logic           tick;
    sched_st_t      state;
    sched_st_t      state_next;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_din;
    logic [7:0]     fifo_dout;
    logic [FCW-1:0] fifo_count;
    logic [15:0]    underflow_q;

    assign tick          = (cnt == CNT_MAX);
    assign fifo_pop      = tick & !fifo_empty;
    assign underflow_cnt = underflow_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ownership only changes through IDLE, so the two streams can never interleave in the FIFO.
    always_comb begin
        state_next = state;
        mod_ready  = 1'b0;
        tst_ready  = 1'b0;
        fifo_push  = 1'b0;
        fifo_din   = mod_data;
        unique case (state)
            ST_IDLE: begin
                if (mod_req) begin
                    state_next = ST_MOD;
                end else if (tst_req) begin
                    state_next = ST_TST;
                end
            end
            ST_MOD: begin
                mod_ready = !fifo_full;
                fifo_push = mod_valid & !fifo_full;
                if (!mod_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_TST: begin
                tst_ready = !fifo_full;
                fifo_din  = tst_data;
                fifo_push = tst_valid & !fifo_full;
                if (!tst_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_count == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Starvation is only counted while a source owns the path; idle and drain gaps are expected.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_stb  <= 1'b0;
            dac_sample  <= MIDSCALE;
            underflow_q <= '0;
            owner       <= 2'd0;
        end else begin
            sample_stb <= tick;
            owner      <= state;
            if (tick) begin
                if (!fifo_empty) begin
                    dac_sample <= fifo_dout;
                end else begin
                    dac_sample <= MIDSCALE;
                    if (state == ST_MOD || state == ST_TST) begin
                        underflow_q <= sat_inc16(underflow_q);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_sched.sv
// Directed bench for dac_sched at DIV = 50: pacing, MOD/TST frames, arbitration,
// starvation counting with saturation, mid-frame reset and simultaneous push/pop.
module tb_dac_sched;

    localparam int TB_DIV = 50;

    logic        sys_clk;
    logic        rst_n;
    logic        mod_req;
    logic [7:0]  mod_data;
    logic        mod_valid;
    logic        mod_ready;
    logic        tst_req;
    logic [7:0]  tst_data;
    logic        tst_valid;
    logic        tst_ready;
    logic [1:0]  owner;
    logic        sample_stb;
    logic [7:0]  dac_sample;
    logic [15:0] underflow_cnt;

    int unsigned nCompared   = 0;
    int unsigned nMismatched = 0;
    bit          seen43      = 1'b0;

    dac_sched #(
        .DIV        (TB_DIV),
        .FIFO_DEPTH (16),
        .MIDSCALE   (8'h80)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .mod_req       (mod_req),
        .mod_data      (mod_data),
        .mod_valid     (mod_valid),
        .mod_ready     (mod_ready),
        .tst_req       (tst_req),
        .tst_data      (tst_data),
        .tst_valid     (tst_valid),
        .tst_ready     (tst_ready),
        .owner         (owner),
        .sample_stb    (sample_stb),
        .dac_sample    (dac_sample),
        .underflow_cnt (underflow_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(negedge sys_clk);
    endtask

    // Returns at the negedge on which sample_stb is seen high.
    task automatic waitStrobe(input string tag, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            cycles++;
            if (sample_stb) found = 1'b1;
        end
        if (!found) checkOutput(tag, {31'd0, sample_stb}, 32'd1);
    endtask

    // Presents one sample from the selected source and holds it until accepted.
    task automatic applyStimulus(input bit useTst, input logic [7:0] d);
        bit accepted;
        accepted = 1'b0;
        if (useTst) begin
            tst_data  = d;
            tst_valid = 1'b1;
        end else begin
            mod_data  = d;
            mod_valid = 1'b1;
        end
        for (int i = 0; i < 300 && !accepted; i++) begin
            if (useTst ? tst_ready : mod_ready) accepted = 1'b1;
            cycle();
        end
        if (useTst) tst_valid = 1'b0;
        else        mod_valid = 1'b0;
        if (!accepted) checkOutput(useTst ? "tst_push_timeout" : "mod_push_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] exp3 [6];
        exp3 = '{8'h41, 8'h42, 8'h43, 8'hC1, 8'hC2, 8'hC3};

        rst_n     = 1'b0;
        mod_req   = 1'b0;
        mod_data  = 8'h00;
        mod_valid = 1'b0;
        tst_req   = 1'b0;
        tst_data  = 8'h00;
        tst_valid = 1'b0;
        repeat (3) cycle();

        $display("[TB] reset state");
        checkOutput("rst_dac", dac_sample, 8'h80);
        checkOutput("rst_stb", sample_stb, 0);
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_mod_ready", mod_ready, 0);
        checkOutput("rst_tst_ready", tst_ready, 0);
        checkOutput("rst_underflow", underflow_cnt, 0);

        $display("[TB] idle pacing");
        rst_n = 1'b1;
        waitStrobe("idle_stb_timeout", n);
        checkOutput("idle_first_stb", n, TB_DIV);
        for (int k = 0; k < 2; k++) begin
            waitStrobe("idle_stb_timeout", n);
            checkOutput("idle_period", n, TB_DIV);
            checkOutput("idle_dac", dac_sample, 8'h80);
            checkOutput("idle_owner", owner, 0);
            checkOutput("idle_underflow", underflow_cnt, 0);
        end

        $display("[TB] MOD frame 01..20");
        mod_req = 1'b1;
        fork
            begin
                for (int d = 1; d <= 32; d++) applyStimulus(1'b0, 8'(d));
            end
            begin
                for (int k = 1; k <= 32; k++) begin
                    int m;
                    waitStrobe("mod_stb_timeout", m);
                    checkOutput("mod_seq", dac_sample, k);
                end
            end
            begin
                repeat (20) cycle();
                checkOutput("mod_full_ready", mod_ready, 0);
                checkOutput("mod_full_count", dut.fifo_count, 16);
                checkOutput("mod_owner", owner, 1);
            end
        join
        mod_req = 1'b0;
        checkOutput("mod_underflow", underflow_cnt, 0);
        repeat (5) cycle();
        checkOutput("mod_end_owner", owner, 0);

        $display("[TB] simultaneous requests");
        waitStrobe("sync_stb_timeout", n);
        mod_req = 1'b1;
        tst_req = 1'b1;
        fork
            begin
                applyStimulus(1'b0, 8'h41);
                applyStimulus(1'b0, 8'h42);
                applyStimulus(1'b0, 8'h43);
                mod_req = 1'b0;
            end
            begin
                applyStimulus(1'b1, 8'hC1);
                applyStimulus(1'b1, 8'hC2);
                applyStimulus(1'b1, 8'hC3);
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    int m;
                    waitStrobe("arb_stb_timeout", m);
                    checkOutput("arb_seq", dac_sample, exp3[k]);
                    if (k == 2) seen43 = 1'b1;
                end
            end
            begin
                int early;
                early = 0;
                repeat (2) cycle();
                checkOutput("arb_owner_mod", owner, 1);
                for (int i = 0; i < 400 && !seen43; i++) begin
                    if (tst_ready) early++;
                    cycle();
                end
                checkOutput("arb_tst_ready_early", early, 0);
            end
        join
        checkOutput("arb_owner_tst", owner, 2);
        checkOutput("arb_underflow", underflow_cnt, 0);

        $display("[TB] TST starvation");
        for (int k = 0; k < 3; k++) begin
            waitStrobe("starve_stb_timeout", n);
            checkOutput("starve_dac", dac_sample, 8'h80);
        end
        checkOutput("starve_count", underflow_cnt, 3);
        force dut.underflow_q = 16'hFFFE;
        #1;
        release dut.underflow_q;
        for (int k = 0; k < 3; k++) begin
            waitStrobe("sat_stb_timeout", n);
            checkOutput("sat_count", underflow_cnt, 16'hFFFF);
        end

        $display("[TB] mid-frame reset");
        tst_req = 1'b0;
        waitStrobe("rst_sync_timeout", n);
        mod_req = 1'b1;
        for (int d = 8'h51; d <= 8'h5B; d++) applyStimulus(1'b0, 8'(d));
        waitStrobe("rst_stb_timeout", n);
        checkOutput("pre_rst_dac", dac_sample, 8'h51);
        checkOutput("pre_rst_count", dut.fifo_count, 10);
        mod_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        checkOutput("midrst_dac", dac_sample, 8'h80);
        checkOutput("midrst_owner", owner, 0);
        checkOutput("midrst_empty", dut.fifo_empty, 1);
        checkOutput("midrst_cnt", dut.cnt, 0);
        checkOutput("midrst_stb", sample_stb, 0);
        checkOutput("midrst_underflow", underflow_cnt, 0);
        cycle();
        rst_n = 1'b1;
        waitStrobe("post_rst_timeout", n);
        checkOutput("post_rst_first_stb", n, TB_DIV);

        $display("[TB] push and pop in one cycle");
        mod_req = 1'b1;
        for (int d = 8'hA1; d <= 8'hA5; d++) applyStimulus(1'b0, 8'(d));
        for (int i = 0; i < 100 && dut.cnt != 6'(TB_DIV - 1); i++) cycle();
        checkOutput("pp_sync", dut.cnt, TB_DIV - 1);
        checkOutput("pp_pre_count", dut.fifo_count, 5);
        mod_data  = 8'hA6;
        mod_valid = 1'b1;
        cycle();
        mod_valid = 1'b0;
        checkOutput("pp_stb", sample_stb, 1);
        checkOutput("pp_dac", dac_sample, 8'hA1);
        checkOutput("pp_count", dut.fifo_count, 5);
        for (int k = 2; k <= 6; k++) begin
            waitStrobe("pp_stb_timeout", n);
            checkOutput("pp_order", dac_sample, 8'hA0 + k);
        end
        mod_req = 1'b0;
        checkOutput("pp_underflow", underflow_cnt, 0);
        repeat (5) cycle();
        checkOutput("pp_end_owner", owner, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
